// File: rtl/agc_a2_timer_if.sv
// Signal bundle between the AGC Block II A2 timer and the rest of the machine.
// The timer drives through the master modport; consumers attach to the slave modport.
interface agc_a2_timer_if;
   logic SBY, ALGA, MSTRTP, STRT1, STRT2, GOJ1, MSTP;
   logic WL15, WL15_, WL16, WL16_;
   logic CLK, PHS2, PHS2_, PHS3_, PHS4, PHS4_;
   logic CT, CT_, RT, RT_, WT, WT_, TT_, OVFSTB_, MONWT, Q2A;
   logic RINGA_, RINGB_, ODDSET_, EVNSET, EVNSET_;
   logic P01, P02, P03, P04, P05, P01_, P02_, P03_, P04_, P05_;
   logic F01A, F01B, F01C, F01D, FS01, FS01_;
   logic SB0, SB0_, SB1, SB1_, SB2, SB2_, SB4, EDSET;
   logic STOPA, GOJAM, GOJAM_, STOP, STOP_, TIMR, MSTPIT_, MGOJAM;
   logic T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12;
   logic T01_, T02_, T03_, T04_, T05_, T06_, T07_, T08_, T09_, T10_, T11_, T12_;
   logic T01DC_, T02DC_, T03DC_, T04DC_, T05DC_, T06DC_, T07DC_, T08DC_, T09DC_, T10DC_, T12DC_;
   logic MT01, MT02, MT03, MT04, MT05, MT06, MT07, MT08, MT09, MT10, MT11, MT12, T12SET;
   logic UNF, UNF_, OVF, OVF_;

   modport master (
      input  SBY, ALGA, MSTRTP, STRT1, STRT2, GOJ1, MSTP, WL15, WL15_, WL16, WL16_,
      output CLK, PHS2, PHS2_, PHS3_, PHS4, PHS4_,
      output CT, CT_, RT, RT_, WT, WT_, TT_, OVFSTB_, MONWT, Q2A,
      output RINGA_, RINGB_, ODDSET_, EVNSET, EVNSET_,
      output P01, P02, P03, P04, P05, P01_, P02_, P03_, P04_, P05_,
      output F01A, F01B, F01C, F01D, FS01, FS01_,
      output SB0, SB0_, SB1, SB1_, SB2, SB2_, SB4, EDSET,
      output STOPA, GOJAM, GOJAM_, STOP, STOP_, TIMR, MSTPIT_, MGOJAM,
      output T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12,
      output T01_, T02_, T03_, T04_, T05_, T06_, T07_, T08_, T09_, T10_, T11_, T12_,
      output T01DC_, T02DC_, T03DC_, T04DC_, T05DC_, T06DC_, T07DC_, T08DC_, T09DC_, T10DC_, T12DC_,
      output MT01, MT02, MT03, MT04, MT05, MT06, MT07, MT08, MT09, MT10, MT11, MT12, T12SET,
      output UNF, UNF_, OVF, OVF_
   );

   modport slave (
      output SBY, ALGA, MSTRTP, STRT1, STRT2, GOJ1, MSTP, WL15, WL15_, WL16, WL16_,
      input  CLK, PHS2, PHS2_, PHS3_, PHS4, PHS4_,
      input  CT, CT_, RT, RT_, WT, WT_, TT_, OVFSTB_, MONWT, Q2A,
      input  RINGA_, RINGB_, ODDSET_, EVNSET, EVNSET_,
      input  P01, P02, P03, P04, P05, P01_, P02_, P03_, P04_, P05_,
      input  F01A, F01B, F01C, F01D, FS01, FS01_,
      input  SB0, SB0_, SB1, SB1_, SB2, SB2_, SB4, EDSET,
      input  STOPA, GOJAM, GOJAM_, STOP, STOP_, TIMR, MSTPIT_, MGOJAM,
      input  T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12,
      input  T01_, T02_, T03_, T04_, T05_, T06_, T07_, T08_, T09_, T10_, T11_, T12_,
      input  T01DC_, T02DC_, T03DC_, T04DC_, T05DC_, T06DC_, T07DC_, T08DC_, T09DC_, T10DC_, T12DC_,
      input  MT01, MT02, MT03, MT04, MT05, MT06, MT07, MT08, MT09, MT10, MT11, MT12, T12SET,
      input  UNF, UNF_, OVF, OVF_
   );
endinterface

// File: rtl/agc_a2_timer.sv
// AGC Block II A2 timer: phases, T01..T12, P/F divider, GOJAM/STOP control, OVF/UNF latch.
// Define A2_TIMER_MONITOR_EN to drive the MT01..MT12 / MONWT / MGOJAM monitor copies.
module agc_a2_timer #(
   parameter int GOJ_EXT = 1
) (
   input logic              CLOCK,
   input logic              RESET_,
   agc_a2_timer_if.master   bus
);
   localparam int EXT_CYC = 48 * GOJ_EXT;
   localparam int EXT_W   = $clog2(EXT_CYC + 2);

   logic [1:0]       ph_q, ph_d;
   logic [3:0]       t_q, t_d;
   logic [1:0]       dph_q;
   logic [4:0]       p_q, p_d;
   logic             fs_q, fs_d;
   logic [4:0]       fs_sr_q;
   logic [4:0]       strt_s1_q, strt_s2_q;
   logic [EXT_W-1:0] ext_q, ext_d;
   logic             gojam_q, gojam_d;
   logic             stop_q, stop_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic [11:0]      tp;
   logic             run, rt, wt, ct, phs2;
   logic             f01a, f01b, f01c, f01d;

   always_comb begin
      ext_d = ext_q;
      if (|strt_s2_q)
         ext_d = EXT_W'(EXT_CYC);
      else if (ext_q != '0)
         ext_d = ext_q - 1'b1;
      // Computing GOJAM one cycle ahead lets the PH/T forcing land on the same edge GOJAM rises.
      gojam_d = (|strt_s1_q) | (ext_d != '0);
      stop_d  = bus.SBY | (bus.MSTP & ~gojam_q);

      ph_d = ph_q + 2'd1;
      t_d  = t_q;
      if (ph_q == 2'd3)
         t_d = (t_q == 4'd11) ? 4'd0 : t_q + 4'd1;
      if (gojam_d) begin
         ph_d = 2'd3;
         t_d  = 4'd11;
      end else if (stop_d) begin
         ph_d = ph_q;
         t_d  = t_q;
      end else if (stop_q) begin
         ph_d = 2'd0;
         t_d  = 4'd0;
      end

      p_d  = p_q;
      fs_d = fs_q;
      if (dph_q == 2'd3) begin
         p_d = {p_q[3:0], ~p_q[4]};
         if (p_q[4] & ~p_d[4])
            fs_d = ~fs_q;
      end

      ovf_d = ovf_q;
      unf_d = unf_q;
      if (gojam_d) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else if (ph_q == 2'd2) begin
         ovf_d = bus.WL16 & bus.WL15_;
         unf_d = bus.WL16_ & bus.WL15;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_) begin
      if (!RESET_) begin
         ph_q      <= 2'd0;
         t_q       <= 4'd0;
         dph_q     <= 2'd0;
         p_q       <= 5'd0;
         fs_q      <= 1'b0;
         fs_sr_q   <= 5'd0;
         strt_s1_q <= 5'd0;
         strt_s2_q <= 5'd0;
         ext_q     <= '0;
         gojam_q   <= 1'b0;
         stop_q    <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         ph_q      <= ph_d;
         t_q       <= t_d;
         dph_q     <= dph_q + 2'd1;
         p_q       <= p_d;
         fs_q      <= fs_d;
         fs_sr_q   <= {fs_sr_q[3:0], fs_q};
         strt_s1_q <= {bus.ALGA, bus.MSTRTP, bus.STRT1, bus.STRT2, bus.GOJ1};
         strt_s2_q <= strt_s1_q;
         ext_q     <= ext_d;
         gojam_q   <= gojam_d;
         stop_q    <= stop_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   for (genvar gi = 0; gi < 12; gi++) begin : g_tp
      assign tp[gi] = ~stop_q & (t_q == 4'(gi));
   end

   assign run  = ~stop_q;
   assign phs2 = (ph_q == 2'd1);
   assign rt   = run & (ph_q == 2'd0 || ph_q == 2'd1);
   assign wt   = run & (ph_q == 2'd1 || ph_q == 2'd2);
   assign ct   = run & (ph_q == 2'd3);

   assign bus.CLK     = (ph_q == 2'd0 || ph_q == 2'd1);
   assign bus.PHS2    = phs2;
   assign bus.PHS2_   = ~phs2;
   assign bus.PHS3_   = ~(ph_q == 2'd2);
   assign bus.PHS4    = (ph_q == 2'd3);
   assign bus.PHS4_   = ~(ph_q == 2'd3);
   assign bus.RT      = rt;
   assign bus.RT_     = ~rt;
   assign bus.WT      = wt;
   assign bus.WT_     = ~wt;
   assign bus.CT      = ct;
   assign bus.CT_     = ~ct;
   assign bus.TT_     = ~(run & (ph_q == 2'd2));
   assign bus.OVFSTB_ = ~(ph_q == 2'd2);
   assign bus.Q2A     = phs2 & ~stop_q;

   // T01 is index 0, so odd-numbered pulses sit on even bit positions.
   assign bus.ODDSET_ = ~|(tp & 12'h555);
   assign bus.RINGA_  = ~|(tp & 12'h555);
   assign bus.EVNSET  = |(tp & 12'hAAA);
   assign bus.EVNSET_ = ~|(tp & 12'hAAA);
   assign bus.RINGB_  = ~|(tp & 12'hAAA);
   assign bus.T12SET  = tp[11] & (ph_q == 2'd3) & ~gojam_q;

   assign {bus.T12, bus.T11, bus.T10, bus.T09, bus.T08, bus.T07,
           bus.T06, bus.T05, bus.T04, bus.T03, bus.T02, bus.T01} = tp;
   assign {bus.T12_, bus.T11_, bus.T10_, bus.T09_, bus.T08_, bus.T07_,
           bus.T06_, bus.T05_, bus.T04_, bus.T03_, bus.T02_, bus.T01_} = ~tp;
   assign {bus.T12DC_, bus.T10DC_, bus.T09DC_, bus.T08DC_, bus.T07DC_,
           bus.T06DC_, bus.T05DC_, bus.T04DC_, bus.T03DC_, bus.T02DC_, bus.T01DC_} =
          ~{tp[11], tp[9:0]};

   assign {bus.P05, bus.P04, bus.P03, bus.P02, bus.P01}      = p_q;
   assign {bus.P05_, bus.P04_, bus.P03_, bus.P02_, bus.P01_} = ~p_q;
   assign bus.FS01  = fs_q;
   assign bus.FS01_ = ~fs_q;

   assign f01a = fs_q & ~fs_sr_q[0];
   assign f01b = fs_sr_q[3] & ~fs_sr_q[4];
   assign f01c = ~fs_q & fs_sr_q[0];
   assign f01d = ~fs_sr_q[3] & fs_sr_q[4];
   assign bus.F01A  = f01a;
   assign bus.F01B  = f01b;
   assign bus.F01C  = f01c;
   assign bus.F01D  = f01d;
   assign bus.SB0   = f01a & bus.SBY;
   assign bus.SB0_  = ~(f01a & bus.SBY);
   assign bus.SB1   = f01b & bus.SBY;
   assign bus.SB1_  = ~(f01b & bus.SBY);
   assign bus.SB2   = f01c & bus.SBY;
   assign bus.SB2_  = ~(f01c & bus.SBY);
   assign bus.SB4   = f01d & bus.SBY;
   assign bus.EDSET = f01c & ~bus.SBY;

   assign bus.GOJAM   = gojam_q;
   assign bus.GOJAM_  = ~gojam_q;
   assign bus.STOP    = stop_q;
   assign bus.STOP_   = ~stop_q;
   assign bus.STOPA   = stop_q & bus.SBY;
   assign bus.TIMR    = gojam_q | stop_q;
   assign bus.MSTPIT_ = ~bus.MSTP;
   assign bus.OVF     = ovf_q;
   assign bus.OVF_    = ~ovf_q;
   assign bus.UNF     = unf_q;
   assign bus.UNF_    = ~unf_q;

`ifdef A2_TIMER_MONITOR_EN
   assign {bus.MT12, bus.MT11, bus.MT10, bus.MT09, bus.MT08, bus.MT07,
           bus.MT06, bus.MT05, bus.MT04, bus.MT03, bus.MT02, bus.MT01} = tp;
   assign bus.MONWT  = wt;
   assign bus.MGOJAM = gojam_q;
`else
   assign {bus.MT12, bus.MT11, bus.MT10, bus.MT09, bus.MT08, bus.MT07,
           bus.MT06, bus.MT05, bus.MT04, bus.MT03, bus.MT02, bus.MT01} = 12'd0;
   assign bus.MONWT  = 1'b0;
   assign bus.MGOJAM = 1'b0;
`endif
endmodule

// File: tb/tb_agc_a2_timer.sv
// Directed bench for agc_a2_timer: MCT sequencing, divider, GOJAM, STOP, OVF/UNF, async reset, standby.
module tb_agc_a2_timer;
`ifdef A2_TIMER_MONITOR_EN
   localparam logic MON = 1'b1;
`else
   localparam logic MON = 1'b0;
`endif

   logic clock;
   logic reset_n;
   int   n_vec;
   int   n_err;

   agc_a2_timer_if bus ();

   agc_a2_timer dut (
      .CLOCK  (clock),
      .RESET_ (reset_n),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         $display("vec %0d %s = %0h", n_vec, tag, obs);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   function automatic logic [11:0] tvec();
      return {bus.T12, bus.T11, bus.T10, bus.T09, bus.T08, bus.T07,
              bus.T06, bus.T05, bus.T04, bus.T03, bus.T02, bus.T01};
   endfunction

   function automatic logic [4:0] pvec();
      return {bus.P05, bus.P04, bus.P03, bus.P02, bus.P01};
   endfunction

   // Johnson sequence after k time pulses, as {P05..P01}.
   function automatic logic [4:0] jstate(input int k);
      int           m;
      logic [4:0]   ones;
      m    = k % 10;
      ones = 5'h1f;
      if (m <= 5) return 5'((32'd1 << m) - 1);
      return ones << (m - 5);
   endfunction

   task automatic set_wl(input logic w16, input logic w15);
      bus.WL16  = w16;
      bus.WL16_ = ~w16;
      bus.WL15  = w15;
      bus.WL15_ = ~w15;
   endtask

   initial begin
      int cnt, c_t12s, c_f01a, c_f01c, c_ed, c_sb, c_sb0, c_sb1, c_sb2, c_sb4;
      n_vec = 0;
      n_err = 0;
      reset_n = 1'b0;
      bus.SBY = 0; bus.ALGA = 0; bus.MSTRTP = 0; bus.STRT1 = 0;
      bus.STRT2 = 0; bus.GOJ1 = 0; bus.MSTP = 0;
      set_wl(1'b0, 1'b0);

      // Reset state
      tick();
      chk("rst_T", 32'(tvec()), 32'h001);
      chk("rst_T01_", 32'(bus.T01_), 32'd0);
      chk("rst_CLK", 32'(bus.CLK), 32'd1);
      chk("rst_PHS2", 32'(bus.PHS2), 32'd0);
      chk("rst_P", 32'(pvec()), 32'd0);
      chk("rst_FS01", 32'(bus.FS01), 32'd0);
      chk("rst_GOJAM_", 32'({bus.GOJAM, bus.GOJAM_}), 32'b01);
      chk("rst_STOP_", 32'({bus.STOP, bus.STOP_}), 32'b01);
      chk("rst_OVF_UNF", 32'({bus.OVF, bus.OVF_, bus.UNF, bus.UNF_}), 32'b0101);

      // Free run: 88 cycles = 22 time pulses
      reset_n = 1'b1;
      c_t12s = 0; c_f01a = 0; c_f01c = 0; c_ed = 0; c_sb = 0;
      for (int n = 0; n < 88; n++) begin
         chk($sformatf("run%0d_T", n), 32'(tvec()), 32'(12'(1) << ((n / 4) % 12)));
         chk($sformatf("run%0d_PHS2", n), 32'(bus.PHS2), 32'(n % 4 == 1));
         chk($sformatf("run%0d_P", n), 32'(pvec()), 32'(jstate(n / 4)));
         chk($sformatf("run%0d_FS01", n), 32'(bus.FS01), 32'((n / 40) % 2));
         if (n == 4) chk("run_EVNSET_T02", 32'({bus.EVNSET, bus.ODDSET_}), 32'b11);
         if (n == 8) chk("run_EVNSET_T03", 32'({bus.EVNSET, bus.ODDSET_}), 32'b00);
         c_t12s += int'(bus.T12SET);
         c_f01a += int'(bus.F01A);
         c_f01c += int'(bus.F01C);
         c_ed   += int'(bus.EDSET);
         c_sb   += int'(bus.SB0) + int'(bus.SB1) + int'(bus.SB2) + int'(bus.SB4);
         tick();
      end
      chk("run_T12SET_cnt", 32'(c_t12s), 32'd1);
      chk("run_F01A_cnt", 32'(c_f01a), 32'd1);
      chk("run_F01C_cnt", 32'(c_f01c), 32'd1);
      chk("run_EDSET_cnt", 32'(c_ed), 32'd1);
      chk("run_SB_cnt", 32'(c_sb), 32'd0);

      // GOJAM from STRT1
      bus.STRT1 = 1'b1;
      tick();
      chk("gj_early", 32'(bus.GOJAM), 32'd0);
      tick();
      chk("gj_on", 32'(bus.GOJAM), 32'd1);
      chk("gj_T12", 32'(tvec()), 32'h800);
      chk("gj_MGOJAM", 32'(bus.MGOJAM), 32'(MON));
      repeat (10) tick();
      chk("gj_hold_T12", 32'(tvec()), 32'h800);
      chk("gj_TIMR", 32'(bus.TIMR), 32'd1);
      bus.STRT1 = 1'b0;
      cnt = 0;
      for (int i = 0; i < 49; i++) begin
         tick();
         cnt += int'(bus.GOJAM);
      end
      chk("gj_ext_cycles", 32'(cnt), 32'd49);
      tick();
      chk("gj_off", 32'(bus.GOJAM), 32'd0);
      chk("gj_first_T01", 32'(tvec()), 32'h001);
      chk("gj_first_PH1", 32'({bus.CLK, bus.PHS2}), 32'b10);

      // STOP mid-T06
      repeat (21) tick();
      chk("stp_T06", 32'(tvec()), 32'h020);
      bus.MSTP = 1'b1;
      tick();
      chk("stp_STOP", 32'(bus.STOP), 32'd1);
      chk("stp_T0", 32'(tvec()), 32'h000);
      chk("stp_RTWT", 32'({bus.RT, bus.WT}), 32'b00);
      chk("stp_MSTPIT_", 32'(bus.MSTPIT_), 32'd0);
      chk("stp_TIMR_STOPA", 32'({bus.TIMR, bus.STOPA}), 32'b10);
      repeat (5) tick();
      chk("stp_hold_T0", 32'(tvec()), 32'h000);
      bus.MSTP = 1'b0;
      tick();
      chk("stp_release", 32'(bus.STOP), 32'd0);
      chk("stp_T01", 32'(tvec()), 32'h001);
      chk("stp_PH1", 32'({bus.CLK, bus.PHS2, bus.RT}), 32'b101);
      chk("stp_MSTPIT_1", 32'(bus.MSTPIT_), 32'd1);

      // OVF / UNF latching, cleared by GOJAM
      set_wl(1'b1, 1'b0);
      repeat (2) tick();
      chk("ovf_before_strobe", 32'(bus.OVF), 32'd0);
      tick();
      chk("ovf_set", 32'({bus.OVF, bus.OVF_, bus.UNF}), 32'b100);
      set_wl(1'b0, 1'b1);
      repeat (4) tick();
      chk("unf_set", 32'({bus.UNF, bus.UNF_, bus.OVF}), 32'b100);
      set_wl(1'b1, 1'b0);
      repeat (4) tick();
      chk("ovf_set2", 32'({bus.OVF, bus.UNF}), 32'b10);
      bus.GOJ1 = 1'b1;
      repeat (2) tick();
      chk("goj1_on", 32'(bus.GOJAM), 32'd1);
      chk("goj1_clear", 32'({bus.OVF, bus.UNF}), 32'b00);
      bus.GOJ1 = 1'b0;
      repeat (50) tick();
      chk("goj1_off_T01", 32'({bus.GOJAM, tvec()}), 32'h001);
      set_wl(1'b0, 1'b0);

      // Async reset mid-T07
      repeat (25) tick();
      chk("ar_T07", 32'(tvec()), 32'h040);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_T01", 32'(tvec()), 32'h001);
      chk("ar_PH1", 32'({bus.CLK, bus.PHS2}), 32'b10);
      chk("ar_P_FS", 32'({pvec(), bus.FS01, bus.FS01_}), 32'b0000001);
      tick();
      reset_n = 1'b1;
      for (int n = 0; n < 8; n++) begin
         chk($sformatf("ar_resume%0d", n), 32'(tvec()), 32'(12'(1) << (n / 4)));
         tick();
      end

      // Standby: divider pulses routed to SB0..SB4
      reset_n = 1'b0;
      tick();
      bus.SBY = 1'b1;
      reset_n = 1'b1;
      c_sb0 = 0; c_sb1 = 0; c_sb2 = 0; c_sb4 = 0; c_ed = 0;
      for (int n = 0; n < 88; n++) begin
         c_sb0 += int'(bus.SB0);
         c_sb1 += int'(bus.SB1);
         c_sb2 += int'(bus.SB2);
         c_sb4 += int'(bus.SB4);
         c_ed  += int'(bus.EDSET);
         tick();
      end
      chk("sby_SB0", 32'(c_sb0), 32'd1);
      chk("sby_SB1", 32'(c_sb1), 32'd1);
      chk("sby_SB2", 32'(c_sb2), 32'd1);
      chk("sby_SB4", 32'(c_sb4), 32'd1);
      chk("sby_EDSET", 32'(c_ed), 32'd0);
      chk("sby_STOP_STOPA", 32'({bus.STOP, bus.STOPA}), 32'b11);
      chk("sby_T0", 32'(tvec()), 32'h000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/agc_a2_timer.md
Name: agc_a2_timer

Overview:
- Synchronous RTL model of the AGC Block II A2 timer module.
- Generates:
  - the four-phase timing strobes (RT/WT/CT/TT);
  - the 12 time pulses T01..T12 that make up one memory cycle time (MCT);
  - the P01..P05 divider and the FS01/F01x first scaler stage;
  - standby pulses.
- Also owns the GOJAM restart and STOP logic, and latches overflow/underflow from WL15/WL16.
- Feeds every other AGC module.

Parameters:
- GOJ_EXT, 1, number of full MCTs GOJAM stays asserted after all start sources clear.

Ports:
- CLOCK  in  1  master clock; every register uses its rising edge.
- RESET_  in  1  asynchronous active-low reset.
- SBY, ALGA, MSTRTP, STRT1, STRT2, GOJ1, MSTP  in  1 each  standby, alarm, manual start, start 1/2, software GOJAM request, manual stop.
- WL15, WL15_, WL16, WL16_  in  1 each  write-line bits 15/16 and their complements.
- CLK, PHS2, PHS2_, PHS3_, PHS4, PHS4_  out  1 each  phase strobes.
- CT, CT_, RT, RT_, WT, WT_, TT_, OVFSTB_, MONWT, Q2A  out  1 each  clear/read/write/test strobes.
- RINGA_, RINGB_, ODDSET_, EVNSET, EVNSET_  out  1 each  ring/parity outputs.
- P01..P05 and P01_..P05_  out  1 each  divider stages and complements.
- F01A, F01B, F01C, F01D, FS01, FS01_  out  1 each  scaler stage 1.
- SB0, SB0_, SB1, SB1_, SB2, SB2_, SB4, EDSET  out  1 each  standby/edit pulses.
- STOPA, GOJAM, GOJAM_, STOP, STOP_, TIMR, MSTPIT_, MGOJAM  out  1 each  control outputs.
- T01..T12, T01_..T12_  out  1 each  time pulses and complements.
- T01DC_..T10DC_, T12DC_  out  1 each  active-low time pulses (there is no T11DC_).
- MT01..MT12, T12SET  out  1 each  monitor copies of the time pulses; T12SET is the end-of-MCT strobe.
- UNF, UNF_, OVF, OVF_  out  1 each  underflow/overflow flags.

Behaviour:
- Phase counter PH (1..4) advances every CLOCK cycle.
  - One time pulse lasts 4 cycles; one MCT lasts 48 cycles.
  - Tn advances to Tn+1 when PH wraps from 4 to 1; T12 wraps to T01.
- Phase-derived strobes:
  - CLK is high when PH is 1 or 2. PHS2 is high when PH=2. PHS3_ is low when PH=3. PHS4 is high when PH=4.
  - RT is high when PH is 1 or 2. WT is high when PH is 2 or 3. CT is high when PH=4. TT_ is low when PH=3.
  - OVFSTB_ is low when PH=3. MONWT equals WT. Q2A equals PHS2 & ~STOP.
- Time-pulse outputs:
  - Exactly one of T01..T12 is high while running; each Tn_ and TnDC_ equals ~Tn.
  - ODDSET_ is low during odd time pulses. EVNSET is high during even time pulses. RINGA_ equals ODDSET_ and RINGB_ equals EVNSET_.
  - T12SET pulses for one cycle at T12, PH=4.
- Divider and scaler:
  - P01..P05 form a 10-state Johnson counter advancing once per time pulse.
  - FS01 toggles whenever P05 falls.
  - F01A pulses for one cycle at FS01 rise; F01B pulses one time pulse later. F01C pulses at FS01 fall; F01D pulses one time pulse later.
  - SB0 = F01A, SB1 = F01B, SB2 = F01C, SB4 = F01D, each gated by SBY. EDSET = F01C & ~SBY.
- Start and GOJAM:
  - Start sources are ALGA, MSTRTP, STRT1, STRT2 and GOJ1, each synchronised through 2 flops.
  - GOJAM asserts 2 cycles after any start source goes high.
  - GOJAM holds while any source is high, then for GOJ_EXT complete MCTs after the last source drops.
  - While GOJAM is asserted, PH and the time-pulse counter are forced to PH=4 of T12. The first time pulse after GOJAM releases is T01, PH=1.
  - The P/F divider keeps running during GOJAM.
- Stop:
  - STOP = SBY | (MSTP & ~GOJAM), registered.
  - While STOP is high: all Tn are low, RT/WT/CT/TT are inactive, and PH freezes. Timing restarts at T01 when STOP drops.
  - STOPA = STOP & SBY. MSTPIT_ = ~MSTP. TIMR = GOJAM | STOP.
- Overflow/underflow:
  - OVF/UNF are latched when OVFSTB_ is low: OVF = WL16 & WL15_, UNF = WL16_ & WL15.
  - Both clear at GOJAM. UNF_ = ~UNF and OVF_ = ~OVF.
- Simultaneous GOJAM and STOP: GOJAM wins for the PH/T forcing; STOP still blanks the strobes.
- Reset (RESET_ low):
  - PH=1, T01 high, P01..P05=0, FS01=0, GOJAM=0, STOP=0, OVF=UNF=0.
  - Every _ output takes the complement of its true signal.
  - Reset asserted mid-MCT overrides everything on the next evaluation, since it is asynchronous.

Optional Feature:
- A2_TIMER_MONITOR_EN defined: MT01..MT12 equal T01..T12, MONWT equals WT, and MGOJAM equals GOJAM.
- A2_TIMER_MONITOR_EN undefined: MT01..MT12, MONWT and MGOJAM are tied to 0.

Test Plan:
- Reset release with no inputs active: T01..T12 each high for 4 cycles in order, T12 back to T01 after 48 cycles. PHS2 is high on the second cycle of every time pulse. T12SET fires once per MCT.
- STRT1=1 at 5 µs, held: GOJAM=1 and MGOJAM=1 within 2 cycles, and all Tn are held at T12. STRT1=0: GOJAM stays high for 48 more cycles, then the first pulse is T01.
- MSTP=1 mid-T06: STOP=1 and all Tn=0. MSTP=0: restart at T01, PH=1. MSTPIT_ tracks ~MSTP.
- WL16=1, WL15=0 during PH=3: OVF=1, OVF_=0. Then WL16=0, WL15=1: UNF=1. A following GOJAM clears both.
- Run 20 time pulses: P01..P05 pass through 10 Johnson states twice and FS01 toggles twice. F01A/F01C each pulse once; SB0..SB4 stay 0 with SBY=0 and pulse with SBY=1.
- RESET_ low mid-T07: all outputs return to reset values immediately; on release, counting resumes from T01.
